// File: rtl/riscv_irq_arbiter_if.sv
// ----------------------------------------------------------------------------
// riscv_irq_arbiter_if
// Handshake between the interrupt arbiter and the core interrupt controller.
//
// Signals:
//   irq_o        arbiter -> controller  interrupt request
//   irq_sec_o    arbiter -> controller  secure bit of the presented id
//   irq_id_o     arbiter -> controller  presented interrupt id
//   irq_ack_i    controller -> arbiter  one-cycle acknowledge pulse
//   irq_ack_id_i controller -> arbiter  id being acknowledged
//
// Modports:
//   master  used by the arbiter (drives the request)
//   slave   used by the controller (drives the acknowledge)
// ----------------------------------------------------------------------------
interface riscv_irq_arbiter_if #(
    parameter int ID_W = 5
);
    logic            irq_o;
    logic            irq_sec_o;
    logic [ID_W-1:0] irq_id_o;
    logic            irq_ack_i;
    logic [ID_W-1:0] irq_ack_id_i;

    modport master (
        output irq_o,
        output irq_sec_o,
        output irq_id_o,
        input  irq_ack_i,
        input  irq_ack_id_i
    );

    modport slave (
        input  irq_o,
        input  irq_sec_o,
        input  irq_id_o,
        output irq_ack_i,
        output irq_ack_id_i
    );
endinterface

// File: rtl/riscv_irq_arbiter.sv
// ----------------------------------------------------------------------------
// riscv_irq_arbiter
// Aggregates NUM_IRQ external interrupt lines into a single request, secure
// bit and id for the core interrupt controller. Each source has an enable,
// a secure attribute and a trigger mode (level, or rising edge latched as
// pending). A registered arbiter picks one winner and holds it stable until
// the core acknowledges it or the source is withdrawn.
//
// Ports:
//   clk             core clock
//   rst_n           asynchronous active-low reset
//   irq_lines_i     raw interrupt lines, synchronous to clk
//   irq_en_mask_i   per-source enable (1 = may request)
//   irq_sec_mask_i  per-source secure attribute
//   irq_edge_i      trigger mode (1 = rising edge latched, 0 = level)
//   irq_bus         controller handshake (master modport):
//                   irq_o / irq_sec_o / irq_id_o out, irq_ack_i / irq_ack_id_i in
//   irq_pending_o   current pending vector (debug / CSR readback)
//
// Build option:
//   IRQ_ARB_RR_EN   when defined, round-robin arbitration with a pointer that
//                   moves to (acked id + 1) mod NUM_IRQ on each matching ack;
//                   otherwise fixed lowest-index priority and no pointer.
// ----------------------------------------------------------------------------
module riscv_irq_arbiter #(
    parameter int NUM_IRQ = 32,
    parameter int ID_W    = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_IRQ-1:0]     irq_lines_i,
    input  logic [NUM_IRQ-1:0]     irq_en_mask_i,
    input  logic [NUM_IRQ-1:0]     irq_sec_mask_i,
    input  logic [NUM_IRQ-1:0]     irq_edge_i,
    riscv_irq_arbiter_if.master    irq_bus,
    output logic [NUM_IRQ-1:0]     irq_pending_o
);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } state_t;

    logic [NUM_IRQ-1:0] lines_r;
    logic [NUM_IRQ-1:0] pending_r;
    logic [NUM_IRQ-1:0] pending_s;
    logic [NUM_IRQ-1:0] rise_s;
    logic [NUM_IRQ-1:0] elig_s;

    state_t             state_r;
    state_t             state_s;
    logic               irq_r;
    logic               irq_s;
    logic               sec_r;
    logic               sec_s;
    logic [ID_W-1:0]    id_r;
    logic [ID_W-1:0]    id_s;

    logic               win_vld_s;
    logic [ID_W-1:0]    win_id_s;
    logic               win_sec_s;
    logic               cur_elig_s;
    logic               ack_match_s;

    assign rise_s      = irq_lines_i & ~lines_r;
    assign elig_s      = pending_r & irq_en_mask_i;
    assign ack_match_s = irq_bus.irq_ack_i & (irq_bus.irq_ack_id_i == id_r);

    // Next pending vector: edge sources latch rises (set beats ack clear), level sources follow the line
    always_comb begin
        pending_s = pending_r;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (irq_edge_i[i]) begin
                if (rise_s[i]) begin
                    pending_s[i] = 1'b1;
                end else if (irq_bus.irq_ack_i && (irq_bus.irq_ack_id_i == ID_W'(i))) begin
                    // ids at or above NUM_IRQ never match any i and are ignored
                    pending_s[i] = 1'b0;
                end else begin
                    pending_s[i] = pending_r[i];
                end
            end else begin
                pending_s[i] = irq_lines_i[i];
            end
        end
    end

`ifdef IRQ_ARB_RR_EN
    logic [ID_W-1:0] rr_ptr_r;
    logic [ID_W-1:0] rr_ptr_s;
    logic            hi_vld_s;
    logic [ID_W-1:0] hi_id_s;
    logic            lo_vld_s;
    logic [ID_W-1:0] lo_id_s;

    // Round-robin winner: lowest eligible index at or above the pointer, else wrap to lowest overall
    always_comb begin
        hi_vld_s = 1'b0;
        hi_id_s  = {ID_W{1'b0}};
        lo_vld_s = 1'b0;
        lo_id_s  = {ID_W{1'b0}};
        // Scanning downwards leaves the lowest matching index in place
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            hi_id_s  = (elig_s[i] && (ID_W'(i) >= rr_ptr_r)) ? ID_W'(i) : hi_id_s;
            hi_vld_s = hi_vld_s | (elig_s[i] & (ID_W'(i) >= rr_ptr_r));
            lo_id_s  = elig_s[i] ? ID_W'(i) : lo_id_s;
            lo_vld_s = lo_vld_s | elig_s[i];
        end
        win_vld_s = lo_vld_s;
        win_id_s  = hi_vld_s ? hi_id_s : lo_id_s;
    end

    // Pointer advances past the acknowledged id, wrapping at NUM_IRQ
    always_comb begin
        rr_ptr_s = rr_ptr_r;
        if ((state_r == ST_PRESENT) && ack_match_s) begin
            rr_ptr_s = (id_r == ID_W'(NUM_IRQ - 1)) ? {ID_W{1'b0}} : (id_r + ID_W'(1));
        end else begin
            rr_ptr_s = rr_ptr_r;
        end
    end

    // Round-robin pointer register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_r <= {ID_W{1'b0}};
        end else begin
            rr_ptr_r <= rr_ptr_s;
        end
    end
`else
    // Fixed-priority winner: lowest eligible index
    always_comb begin
        win_vld_s = 1'b0;
        win_id_s  = {ID_W{1'b0}};
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            win_id_s  = elig_s[i] ? ID_W'(i) : win_id_s;
            win_vld_s = win_vld_s | elig_s[i];
        end
    end
`endif

    // Secure bit of the candidate winner and eligibility of the presented id
    always_comb begin
        win_sec_s  = 1'b0;
        cur_elig_s = 1'b0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            win_sec_s  = win_sec_s  | (irq_sec_mask_i[i] & (win_id_s == ID_W'(i)));
            cur_elig_s = cur_elig_s | (elig_s[i] & (id_r == ID_W'(i)));
        end
    end

    // Presentation FSM next state and next registered outputs
    always_comb begin
        state_s = state_r;
        irq_s   = irq_r;
        sec_s   = sec_r;
        id_s    = id_r;
        case (state_r)
            ST_IDLE: begin
                irq_s = 1'b0;
                if (win_vld_s) begin
                    state_s = ST_PRESENT;
                    irq_s   = 1'b1;
                    id_s    = win_id_s;
                    sec_s   = win_sec_s;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_PRESENT: begin
                // Ack wins over a simultaneous withdrawal; both return to IDLE
                // for at least one cycle so the controller sees irq_o low.
                if (ack_match_s || !cur_elig_s) begin
                    state_s = ST_IDLE;
                    irq_s   = 1'b0;
                    sec_s   = 1'b0;
                end else begin
                    state_s = ST_PRESENT;
                    irq_s   = 1'b1;
                end
            end
            default: begin
                state_s = ST_IDLE;
                irq_s   = 1'b0;
                sec_s   = 1'b0;
            end
        endcase
    end

    // State, line sample, pending and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            lines_r   <= {NUM_IRQ{1'b0}};
            pending_r <= {NUM_IRQ{1'b0}};
            irq_r     <= 1'b0;
            sec_r     <= 1'b0;
            id_r      <= {ID_W{1'b0}};
        end else begin
            state_r   <= state_s;
            lines_r   <= irq_lines_i;
            pending_r <= pending_s;
            irq_r     <= irq_s;
            sec_r     <= sec_s;
            id_r      <= id_s;
        end
    end

    assign irq_bus.irq_o     = irq_r;
    assign irq_bus.irq_sec_o = sec_r;
    assign irq_bus.irq_id_o  = id_r;
    assign irq_pending_o     = pending_r;

endmodule

// File: tb/tb_riscv_irq_arbiter.sv
// ----------------------------------------------------------------------------
// tb_riscv_irq_arbiter
// Self-checking bench: directed scenarios plus randomized stimulus, compared
// every cycle against a transaction-level reference model of the arbiter.
// ----------------------------------------------------------------------------
module tb_riscv_irq_arbiter;
    localparam int N    = 32;
    localparam int ID_W = 5;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] lines = '0;
    logic [N-1:0] en_mask = '0;
    logic [N-1:0] sec_mask = '0;
    logic [N-1:0] edge_mode = '0;
    logic [N-1:0] pending;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    logic [N-1:0] m_pending;
    logic [N-1:0] m_prev;
    bit           m_busy;
    int           m_id;
    bit           m_sec;
    int           m_ptr;

    riscv_irq_arbiter_if #(.ID_W(ID_W)) irq_bus ();

    riscv_irq_arbiter #(.NUM_IRQ(N), .ID_W(ID_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .irq_lines_i    (lines),
        .irq_en_mask_i  (en_mask),
        .irq_sec_mask_i (sec_mask),
        .irq_edge_i     (edge_mode),
        .irq_bus        (irq_bus),
        .irq_pending_o  (pending)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int pick_winner(input logic [N-1:0] el, input int start);
        for (int k = 0; k < N; k++) begin
            if (el[(start + k) % N]) return (start + k) % N;
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_pending = '0;
        m_prev    = '0;
        m_busy    = 1'b0;
        m_id      = 0;
        m_sec     = 1'b0;
        m_ptr     = 0;
    endtask

    // one clock of the interrupt arbiter, described by its observable rules
    task automatic model_step();
        logic [N-1:0] elig;
        logic [N-1:0] next_pend;
        bit           ack_hit;
        int           start;
        elig = m_pending & en_mask;
        for (int i = 0; i < N; i++) begin
            ack_hit = irq_bus.irq_ack_i && (int'(irq_bus.irq_ack_id_i) == i);
            if (edge_mode[i])
                next_pend[i] = (lines[i] && !m_prev[i]) ? 1'b1 : (ack_hit ? 1'b0 : m_pending[i]);
            else
                next_pend[i] = lines[i];
        end
        if (m_busy) begin
            if (irq_bus.irq_ack_i && int'(irq_bus.irq_ack_id_i) == m_id) begin
                m_busy = 1'b0;
                m_sec  = 1'b0;
                m_ptr  = (m_id + 1) % N;
            end else if (!elig[m_id]) begin
                m_busy = 1'b0;
                m_sec  = 1'b0;
            end
        end else if (elig != '0) begin
`ifdef IRQ_ARB_RR_EN
            start = m_ptr;
`else
            start = 0;
`endif
            m_id   = pick_winner(elig, start);
            m_sec  = sec_mask[m_id];
            m_busy = 1'b1;
        end
        m_pending = next_pend;
        m_prev    = lines;
    endtask

    task automatic compare_all(input string tag);
        check_eq({tag, "/irq_o"},     32'(irq_bus.irq_o),     32'(m_busy));
        check_eq({tag, "/irq_sec_o"}, 32'(irq_bus.irq_sec_o), 32'(m_sec));
        check_eq({tag, "/irq_id_o"},  32'(irq_bus.irq_id_o),  32'(m_id));
        check_eq({tag, "/pending"},   32'(pending),           32'(m_pending));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_all("cyc");
    endtask

    // called #1 after a rising edge; asserts reset mid-cycle, releases mid-cycle
    task automatic apply_reset();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        compare_all("rst");
        @(posedge clk);
        #3 rst_n = 1'b1;
        lines     = '0;
        irq_bus.irq_ack_i    = 1'b0;
        irq_bus.irq_ack_id_i = '0;
    endtask

    initial begin
        irq_bus.irq_ack_i    = 1'b0;
        irq_bus.irq_ack_id_i = '0;
        model_reset();
        @(posedge clk);
        #1;
        apply_reset();

        // edge pulse on 7: pending after 1, presented after 2, ack clears
        en_mask = '1; edge_mode = '1;
        lines[7] = 1'b1;
        cycle();
        check_eq("s1_pend7", 32'(pending[7]), 32'd1);
        lines[7] = 1'b0;
        cycle();
        check_eq("s1_irq", 32'(irq_bus.irq_o), 32'd1);
        check_eq("s1_id",  32'(irq_bus.irq_id_o), 32'd7);
        irq_bus.irq_ack_i = 1'b1; irq_bus.irq_ack_id_i = 5'd7;
        cycle();
        irq_bus.irq_ack_i = 1'b0;
        check_eq("s1_ack_irq",  32'(irq_bus.irq_o), 32'd0);
        check_eq("s1_ack_pend", 32'(pending[7]), 32'd0);

        // level sources 3 and 9, withdrawal of 3, then hold 9 against edge 1
        apply_reset();
        en_mask = '1; edge_mode = '0; sec_mask = '0; sec_mask[9] = 1'b1;
        lines[3] = 1'b1; lines[9] = 1'b1;
        cycle();
        cycle();
        check_eq("s2_id3",  32'(irq_bus.irq_id_o), 32'd3);
        check_eq("s2_sec3", 32'(irq_bus.irq_sec_o), 32'd0);
        lines[3] = 1'b0;
        cycle();
        cycle();
        check_eq("s2_gap", 32'(irq_bus.irq_o), 32'd0);
        cycle();
        check_eq("s2_id9",  32'(irq_bus.irq_id_o), 32'd9);
        check_eq("s2_sec9", 32'(irq_bus.irq_sec_o), 32'd1);
        edge_mode[1] = 1'b1; lines[1] = 1'b1;
        cycle();
        cycle();
        check_eq("s3_hold9", 32'(irq_bus.irq_id_o), 32'd9);
        irq_bus.irq_ack_i = 1'b1; irq_bus.irq_ack_id_i = 5'd9;
        cycle();
        irq_bus.irq_ack_i = 1'b0;
        check_eq("s3_gap", 32'(irq_bus.irq_o), 32'd0);
        cycle();
        check_eq("s3_id1", 32'(irq_bus.irq_id_o), 32'd1);
        check_eq("s3_irq", 32'(irq_bus.irq_o), 32'd1);

        // edge 5 re-pulses in the ack cycle: stays pending, re-presented
        apply_reset();
        en_mask = '1; edge_mode = '1; sec_mask = '0;
        lines[5] = 1'b1;
        cycle();
        lines[5] = 1'b0;
        cycle();
        irq_bus.irq_ack_i = 1'b1; irq_bus.irq_ack_id_i = 5'd5; lines[5] = 1'b1;
        cycle();
        irq_bus.irq_ack_i = 1'b0; lines[5] = 1'b0;
        check_eq("s4_pend5", 32'(pending[5]), 32'd1);
        check_eq("s4_gap",   32'(irq_bus.irq_o), 32'd0);
        cycle();
        check_eq("s4_re_id", 32'(irq_bus.irq_id_o), 32'd5);
        check_eq("s4_re_irq", 32'(irq_bus.irq_o), 32'd1);

        // masked pending edge on 12, then enable
        apply_reset();
        en_mask = '1; en_mask[12] = 1'b0; edge_mode = '1;
        lines[12] = 1'b1;
        cycle();
        lines[12] = 1'b0;
        cycle();
        cycle();
        check_eq("s5_masked", 32'(irq_bus.irq_o), 32'd0);
        check_eq("s5_pend12", 32'(pending[12]), 32'd1);
        en_mask[12] = 1'b1;
        cycle();
        check_eq("s5_irq",  32'(irq_bus.irq_o), 32'd1);
        check_eq("s5_id12", 32'(irq_bus.irq_id_o), 32'd12);

`ifdef IRQ_ARB_RR_EN
        // round-robin: level 2 and 4, ack 2 -> 4, ack 4 -> 2
        apply_reset();
        en_mask = '1; edge_mode = '0;
        lines[2] = 1'b1; lines[4] = 1'b1;
        cycle();
        cycle();
        check_eq("rr_id2", 32'(irq_bus.irq_id_o), 32'd2);
        irq_bus.irq_ack_i = 1'b1; irq_bus.irq_ack_id_i = 5'd2;
        cycle();
        irq_bus.irq_ack_i = 1'b0;
        cycle();
        check_eq("rr_id4", 32'(irq_bus.irq_id_o), 32'd4);
        irq_bus.irq_ack_i = 1'b1; irq_bus.irq_ack_id_i = 5'd4;
        cycle();
        irq_bus.irq_ack_i = 1'b0;
        cycle();
        check_eq("rr_wrap2", 32'(irq_bus.irq_id_o), 32'd2);
`endif

        // randomized phase against the model, with one mid-run async reset
        apply_reset();
        en_mask   = N'($urandom()) | N'($urandom());
        edge_mode = N'($urandom());
        sec_mask  = N'($urandom());
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(7, 0) == 0) lines[b] = ~lines[b];
            end
            if ($urandom_range(15, 0) == 0) en_mask   = N'($urandom()) | N'($urandom());
            if ($urandom_range(31, 0) == 0) edge_mode = N'($urandom());
            if ($urandom_range(31, 0) == 0) sec_mask  = N'($urandom());
            irq_bus.irq_ack_i = 1'b0;
            if (m_busy && $urandom_range(3, 0) == 0) begin
                irq_bus.irq_ack_i    = 1'b1;
                irq_bus.irq_ack_id_i = ID_W'(m_id);
            end else if ($urandom_range(15, 0) == 0) begin
                irq_bus.irq_ack_i    = 1'b1;
                irq_bus.irq_ack_id_i = ID_W'($urandom_range(N - 1, 0));
            end
            if (c == 1500) begin
                apply_reset();
            end
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
